// File: rtl/divider_integer_restoring_pkg.sv
// Shared types for the restoring divider: FSM state encoding and counter sizing.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold WORD_WIDTH itself, hence +1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/divider_integer_restoring_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract,
// keep the difference on no-borrow (quotient bit 1) or restore on borrow (bit 0).
module divider_restoring_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_shift;
  logic             w_no_borrow;
  logic [WIDTH-1:0] w_diff;

  assign w_shift     = {i_rem, i_bit};
  assign w_no_borrow = (w_shift >= {1'b0, i_divisor});
  // When the trial succeeds the difference is below the divisor, so the low bits suffice.
  assign w_diff      = w_shift[WIDTH-1:0] - i_divisor;

  assign o_qbit = w_no_borrow;
  assign o_rem  = w_no_borrow ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/divider_integer_restoring.sv
// Multi-cycle restoring divider, one quotient bit per clock behind valid/ready handshakes.
// Unsigned by default; define DIVIDER_SIGNED_EN for two's-complement operands.
import divider_pkg::*;

module divider_integer_restoring #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] dividend,
  input  logic [WORD_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] quotient,
  output logic [WORD_WIDTH-1:0] remainder,
  output logic                  divide_by_zero
);

  localparam int W  = WORD_WIDTH;
  localparam int CW = cnt_width(WORD_WIDTH);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_divisor;
  logic          r_zero;
  logic [W-1:0]  r_quotient;
  logic [W-1:0]  r_remainder;
  logic          r_dbz;

  logic [W-1:0]  w_dividend_mag;
  logic [W-1:0]  w_divisor_mag;
  logic [W-1:0]  w_rem_next;
  logic          w_qbit;
  logic [W-1:0]  w_quo_next;
  logic [W-1:0]  w_quo_final;
  logic [W-1:0]  w_rem_final;

`ifdef DIVIDER_SIGNED_EN
  logic          r_neg_q;
  logic          r_neg_r;
  logic [W-1:0]  r_dividend;

  // Most-negative stays as its own bit pattern, which reads correctly as unsigned magnitude.
  assign w_dividend_mag = dividend[W-1] ? (-dividend) : dividend;
  assign w_divisor_mag  = divisor[W-1]  ? (-divisor)  : divisor;
`else
  assign w_dividend_mag = dividend;
  assign w_divisor_mag  = divisor;
`endif

  divider_restoring_step #(.WIDTH(W)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_quo[W-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  assign w_quo_next = {r_quo[W-2:0], w_qbit};

  always_comb begin
    w_quo_final = w_quo_next;
    w_rem_final = w_rem_next;
`ifdef DIVIDER_SIGNED_EN
    if (r_zero) begin
      w_quo_final = '1;
      w_rem_final = r_dividend;
    end else begin
      if (r_neg_q) w_quo_final = -w_quo_next;
      if (r_neg_r) w_rem_final = -w_rem_next;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_zero      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dividend  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_rem     <= '0;
            r_quo     <= w_dividend_mag;
            r_divisor <= w_divisor_mag;
            r_zero    <= (divisor == '0);
            r_cnt     <= CW'(W);
`ifdef DIVIDER_SIGNED_EN
            r_neg_q    <= dividend[W-1] ^ divisor[W-1];
            r_neg_r    <= dividend[W-1];
            r_dividend <= dividend;
`endif
            r_state   <= CALC;
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_quotient  <= w_quo_final;
            r_remainder <= w_rem_final;
            r_dbz       <= r_zero;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready       = (r_state == IDLE);
  assign out_valid      = (r_state == DONE);
  assign quotient       = r_quotient;
  assign remainder      = r_remainder;
  assign divide_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_integer_restoring.sv
// Directed-vector bench for divider_integer_restoring at WORD_WIDTH=8.
module tb_divider_integer_restoring;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         divide_by_zero;

  int n_err = 0;
  int n_chk = 0;

  divider_integer_restoring #(.WORD_WIDTH(W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dividend       (dividend),
    .divisor        (divisor),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .quotient       (quotient),
    .remainder      (remainder),
    .divide_by_zero (divide_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge (=1) until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check_val({tag, "_ov_after"}, 32'(out_valid), 32'd0);
    check_val({tag, "_ir_after"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    int lat;
    start_div(a, b);
    check_val({tag, "_ir_busy"}, 32'(in_ready), 32'd0);
    wait_result(lat);
    check_val({tag, "_lat"}, 32'(lat), 32'd9);
    check_val({tag, "_q"}, 32'(quotient), 32'(eq));
    check_val({tag, "_r"}, 32'(remainder), 32'(er));
    check_val({tag, "_dbz"}, 32'(divide_by_zero), 32'(ez));
    release_result(tag);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clock);
    check_val("rst_ir", 32'(in_ready), 32'd1);
    check_val("rst_ov", 32'(out_valid), 32'd0);
    check_val("rst_q", 32'(quotient), 32'd0);
    check_val("rst_r", 32'(remainder), 32'd0);
    check_val("rst_dbz", 32'(divide_by_zero), 32'd0);
    reset_n = 1'b1;

    run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    run_div("d5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
    run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    run_div("d3_200", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0);

    // Hold the result with out_ready low while pestering in_valid.
    start_div(8'd100, 8'd9);
    wait_result(lat);
    check_val("stall_lat", 32'(lat), 32'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      dividend = 8'd1;
      divisor  = 8'd1;
      @(posedge clock);
      #1;
      check_val("stall_ov", 32'(out_valid), 32'd1);
      check_val("stall_ir", 32'(in_ready), 32'd0);
      check_val("stall_q", 32'(quotient), 32'd11);
      check_val("stall_r", 32'(remainder), 32'd1);
    end
    in_valid = 1'b0;
    release_result("stall");
    repeat (3) @(posedge clock);
    #1;
    check_val("stall_no_accept", 32'(in_ready), 32'd1);

    // Abort in the 4th CALC cycle; reset must take effect without a clock edge.
    start_div(8'd77, 8'd5);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_val("abort_ir", 32'(in_ready), 32'd1);
    check_val("abort_ov", 32'(out_valid), 32'd0);
    check_val("abort_q", 32'(quotient), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_div("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);

`ifdef DIVIDER_SIGNED_EN
    run_div("s_m7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0);
    run_div("s_7_m2", 8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0);
    run_div("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'd0, 1'b0);
    run_div("s_m5_0", 8'hFB, 8'd0, 8'hFF, 8'hFB, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
